// File: rtl/prio_sel_pipe_pkg.sv
// prio_sel_pipe_pkg
//   Shared definitions for the prio_sel_pipe block:
//   - clog2_min1(): index-width helper (never returns less than 1)
//   - reset constants for the output register
package prio_sel_pipe_pkg;

    // Width of an index able to address n items; at least 1 bit so that
    // single-channel builds still have a legal port width.
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

    localparam logic RST_OUT_VALID = 1'b0;
    localparam int   RST_OUT_DATA  = 0;
    localparam int   RST_OUT_SRC   = 0;

endpackage

// File: rtl/prio_sel_arb.sv
// prio_sel_arb
//   Purely combinational arbiter. Searches the request vector upward from
//   a start index, wrapping from N-1 to 0, and grants the first hit.
//   Ports:
//     i_req  [N]     request vector
//     i_ptr  [IDXW]  start index of the search (0 for fixed priority)
//     o_gnt  [N]     one-hot grant (zero when no request)
//     o_idx  [IDXW]  index of the granted channel (0 when none)
//     o_any          at least one channel granted
module prio_sel_arb #(
    parameter int N    = 6,
    parameter int IDXW = 3
) (
    input  logic [N-1:0]    i_req,
    input  logic [IDXW-1:0] i_ptr,
    output logic [N-1:0]    o_gnt,
    output logic [IDXW-1:0] o_idx,
    output logic            o_any
);

    int w_j;

    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        w_j   = 0;
        for (int i = 0; i < N; i++) begin
            // Pointer is always < N, so a single subtraction wraps it.
            w_j = int'(i_ptr) + i;
            if (w_j >= N) w_j = w_j - N;
            if (!o_any && i_req[w_j]) begin
                o_any      = 1'b1;
                o_gnt[w_j] = 1'b1;
                o_idx      = IDXW'(w_j);
            end
        end
    end

endmodule

// File: rtl/prio_sel_pipe.sv
// prio_sel_pipe
//   Registered N-way priority selector with valid/ready on every input and
//   on the output. One cycle latency, one word per cycle throughput.
//   Optional feature: define PRIO_SEL_PIPE_RR_EN for round-robin arbitration;
//   otherwise fixed priority with channel 0 highest.
//   Ports:
//     clk, rst_n           clock, asynchronous active-low reset
//     in_data  [N*W]       channel k at bits [k*W +: W]
//     in_valid [N]         per-channel request
//     in_ready [N]         per-channel grant (combinational, one-hot or zero)
//     out_data [W]         registered selected word
//     out_src  [IDXW]      channel that supplied out_data
//     out_valid            output register holds a word
//     out_ready            consumer accepts the word
module prio_sel_pipe
    import prio_sel_pipe_pkg::*;
#(
    parameter  int W    = 4,
    parameter  int N    = 6,
    localparam int IDXW = clog2_min1(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N*W-1:0]  in_data,
    input  logic [N-1:0]    in_valid,
    output logic [N-1:0]    in_ready,
    output logic [W-1:0]    out_data,
    output logic [IDXW-1:0] out_src,
    output logic            out_valid,
    input  logic            out_ready
);

    logic [N-1:0]    w_gnt;
    logic [IDXW-1:0] w_idx;
    logic            w_any;
    logic            w_load;
    logic [IDXW-1:0] w_ptr;
    logic [W-1:0]    w_sel;

    logic [W-1:0]    r_data;
    logic [IDXW-1:0] r_src;
    logic            r_valid;

    // Output register can take a word when empty or being drained this cycle.
    assign w_load = !r_valid || out_ready;

    prio_sel_arb #(.N(N), .IDXW(IDXW)) u_arb (
        .i_req (in_valid),
        .i_ptr (w_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_idx),
        .o_any (w_any)
    );

`ifdef PRIO_SEL_PIPE_RR_EN
    logic [IDXW-1:0] r_ptr;

    // Next search starts just past the last winner; idle and stall cycles
    // leave the pointer alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (w_load && w_any) begin
            r_ptr <= (w_idx == IDXW'(N-1)) ? '0 : w_idx + 1'b1;
        end
    end
    assign w_ptr = r_ptr;
`else
    assign w_ptr = '0;
`endif

    // Grant is one-hot, so an AND-OR mux picks the winning word.
    always_comb begin
        w_sel = '0;
        for (int k = 0; k < N; k++) begin
            if (w_gnt[k]) w_sel = w_sel | in_data[k*W +: W];
        end
    end

    // Gate with rst_n so no producer sees a grant while the block is in reset.
    assign in_ready = (rst_n && w_load) ? w_gnt : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= RST_OUT_VALID;
            r_data  <= W'(RST_OUT_DATA);
            r_src   <= IDXW'(RST_OUT_SRC);
        end else if (w_load) begin
            r_valid <= w_any;
            if (w_any) begin
                r_data <= w_sel;
                r_src  <= w_idx;
            end
        end
    end

    assign out_data  = r_data;
    assign out_src   = r_src;
    assign out_valid = r_valid;

endmodule

// File: tb/tb_prio_sel_pipe.sv
module tb_prio_sel_pipe;
    localparam int N = 6;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid, in_ready;
    logic [W-1:0]   out_data;
    logic [2:0]     out_src;
    logic           out_valid, out_ready;

    logic [7:0] c_in_data, c_out_data;
    logic [0:0] c_in_valid, c_in_ready, c_out_src;
    logic       c_out_valid, c_out_ready;

    prio_sel_pipe #(.W(W), .N(N)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .out_data(out_data), .out_src(out_src),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    prio_sel_pipe #(.W(8), .N(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_data(c_in_data), .in_valid(c_in_valid),
        .in_ready(c_in_ready), .out_data(c_out_data), .out_src(c_out_src),
        .out_valid(c_out_valid), .out_ready(c_out_ready)
    );

    int errs = 0;
    int checks = 0;

    // Reference model state: channel contents and the output register.
    logic [W-1:0] chd [N];
    logic [N-1:0] v;
    logic         m_valid;
    logic [W-1:0] m_data;
    int           m_src;
    int           m_ptr;

    function automatic int pick(input logic [N-1:0] req, input int p);
        int k;
        for (int i = 0; i < N; i++) begin
            k = (p + i) % N;
            if (req[k]) return k;
        end
        return -1;
    endfunction

    function automatic int start_idx();
`ifdef PRIO_SEL_PIPE_RR_EN
        return m_ptr;
`else
        return 0;
`endif
    endfunction

    task automatic model_reset();
        m_valid = 1'b0; m_data = '0; m_src = 0; m_ptr = 0;
    endtask

    task automatic drive();
        for (int k = 0; k < N; k++) in_data[k*W +: W] = chd[k];
        in_valid = v;
    endtask

    // One clock cycle: drive, check against model, advance model; producers
    // drop the request that the model says was granted.
    task automatic cyc(input string tag);
        int g;
        bit ld;
        logic [N-1:0] exp_rdy;
        drive();
        #2;
        ld = !m_valid || out_ready;
        g = ld ? pick(v, start_idx()) : -1;
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        checks++;
        if (in_ready !== exp_rdy) begin
            errs++; $display("FAIL %s in_ready got=%b exp=%b", tag, in_ready, exp_rdy);
        end
        checks++;
        if (out_valid !== m_valid) begin
            errs++; $display("FAIL %s out_valid got=%b exp=%b", tag, out_valid, m_valid);
        end
        if (m_valid) begin
            checks++;
            if (out_data !== m_data || out_src !== 3'(m_src)) begin
                errs++;
                $display("FAIL %s out got data=%h src=%0d exp data=%h src=%0d", tag, out_data, out_src, m_data, m_src);
            end
        end
        @(posedge clk); #1;
        if (ld) begin
            if (g >= 0) begin
                m_valid = 1'b1; m_data = chd[g]; m_src = g;
                m_ptr = (g == N-1) ? 0 : g + 1;
                v[g] = 1'b0;
            end else begin
                m_valid = 1'b0;
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic chk_out(input string tag, input logic ev, input logic [W-1:0] ed, input int es);
        checks++;
        if (out_valid !== ev || (ev && (out_data !== ed || out_src !== 3'(es)))) begin
            errs++;
            $display("FAIL %s got v=%b d=%h s=%0d exp v=%b d=%h s=%0d", tag, out_valid, out_data, out_src, ev, ed, es);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; model_reset();
        v = '1; out_ready = 1'b1;
        for (int k = 0; k < N; k++) chd[k] = W'($urandom);
        drive();
        @(posedge clk); #2;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 4'h0 || out_src !== 3'd0 || in_ready !== 6'b0) begin
            errs++;
            $display("FAIL reset got v=%b d=%h s=%0d rdy=%b exp 0/0/0/000000", out_valid, out_data, out_src, in_ready);
        end
        @(posedge clk); #1;
        rst_n = 1'b1; #1;
        checks++;
        if (in_ready !== 6'b000001) begin
            errs++; $display("FAIL reset_release in_ready got=%b exp=000001", in_ready);
        end
        v = '0;
        cyc("reset_idle");
    endtask

    task automatic test_fixed_priority();
        logic [W-1:0] ed [3];
        int es [3];
        ed[0] = 4'h3; ed[1] = 4'h7; ed[2] = 4'hA;
        es[0] = 2; es[1] = 3; es[2] = 5;
        chd[2] = 4'h3; chd[3] = 4'h7; chd[5] = 4'hA;
        v = 6'b101100; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc("prio");
            chk_out("prio_seq", 1'b1, ed[i], es[i]);
        end
        cyc("prio_drain");
        chk_out("prio_drain", 1'b0, '0, 0);
    endtask

    task automatic test_stall();
        v = '0; chd[4] = 4'h9; v[4] = 1'b1; out_ready = 1'b1;
        cyc("stall_load");
        chk_out("stall_load", 1'b1, 4'h9, 4);
        out_ready = 1'b0;
        chd[0] = 4'h5; chd[1] = 4'hC; v[1:0] = 2'b11;
        for (int i = 0; i < 3; i++) begin
            cyc("stall_hold");
            chk_out("stall_hold", 1'b1, 4'h9, 4);
        end
        out_ready = 1'b1;
        cyc("stall_release");
        chk_out("stall_nobubble", 1'b1, 4'h5, 0);
        cyc("stall_next");
        chk_out("stall_next", 1'b1, 4'hC, 1);
        cyc("drain");
        chk_out("drain", 1'b0, '0, 0);
    endtask

    task automatic test_round_robin();
        int es;
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < N; k++) chd[k] = W'(k + 8);
        for (int i = 0; i < 7; i++) begin
            v = '1;
            cyc("rr");
`ifdef PRIO_SEL_PIPE_RR_EN
            es = i % N;
`else
            es = 0;
`endif
            chk_out("rr_seq", 1'b1, W'(es + 8), es);
        end
        v = '0;
        cyc("rr_drain");
    endtask

    task automatic test_reset_midstream();
        v = '1; out_ready = 1'b0;
        cyc("mid_load");
        v = '0;
        #2;
        rst_n = 1'b0; model_reset(); #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 6'b0) begin
            errs++; $display("FAIL mid_reset got v=%b rdy=%b exp v=0 rdy=000000", out_valid, in_ready);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        v = 6'b110100; chd[2] = 4'hE; chd[4] = 4'h1; chd[5] = 4'h2; out_ready = 1'b1;
        cyc("mid_first");
        chk_out("mid_first", 1'b1, 4'hE, 2);
        v = '0;
        cyc("mid_clear");
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            for (int k = 0; k < N; k++) begin
                if (!v[k] && ($urandom % 2 == 0)) begin
                    v[k] = 1'b1; chd[k] = W'($urandom);
                end
            end
            out_ready = ($urandom % 4) != 0;
            cyc("rand");
        end
        v = '0; out_ready = 1'b1;
        cyc("rand_end");
    endtask

    task automatic test_n1();
        logic cm_valid;
        logic [7:0] cm_data;
        logic exp_rdy;
        do_reset();
        cm_valid = 1'b0; cm_data = '0;
        for (int i = 0; i < 40; i++) begin
            c_in_valid  = 1'($urandom);
            c_in_data   = 8'($urandom);
            c_out_ready = 1'($urandom);
            #2;
            exp_rdy = c_in_valid[0] && (!cm_valid || c_out_ready);
            checks++;
            if (c_in_ready[0] !== exp_rdy || c_out_src !== 1'b0 || c_out_valid !== cm_valid ||
                (cm_valid && c_out_data !== cm_data)) begin
                errs++;
                $display("FAIL n1 got rdy=%b src=%0d v=%b d=%h exp rdy=%b src=0 v=%b d=%h",
                         c_in_ready, c_out_src, c_out_valid, c_out_data, exp_rdy, cm_valid, cm_data);
            end
            @(posedge clk); #1;
            if (!cm_valid || c_out_ready) begin
                cm_valid = c_in_valid[0];
                if (c_in_valid[0]) cm_data = c_in_data;
            end
        end
    endtask

    initial begin
        c_in_data = '0; c_in_valid = '0; c_out_ready = 1'b0;
        in_data = '0; in_valid = '0; out_ready = 1'b0; v = '0;
        for (int k = 0; k < N; k++) chd[k] = '0;
        test_reset();
        test_fixed_priority();
        test_stall();
        test_round_robin();
        test_reset_midstream();
        test_random();
        test_n1();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end
endmodule
